lc3_control_fsm: RTL and testbench
==================================

LC3_CONTROL_FSM -- requirements
Module: lc3_control_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2: memory read/write wait cycles, legal range 1..7.
REQ-002 SHALL have port Clk, input, 1: single system clock; all state changes on rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port Run, input, 1: leave HALTED and start fetching.
REQ-005 SHALL have port Continue, input, 1: PAUSE release handshake.
REQ-006 SHALL have port Opcode, input, 4: IR[15:12].
REQ-007 SHALL have port IR_5, input, 1: immediate-select bit for ADD/AND.
REQ-008 SHALL have port BEN, input, 1: registered branch enable from the NZP/BEN datapath.
REQ-009 SHALL have outputs LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED, each 1 bit: register load strobes.
REQ-010 SHALL have outputs GatePC, GateMDR, GateALU, GateMARMUX, each 1 bit: bus drivers, at most one high per cycle.
REQ-011 SHALL have outputs PCMUX (2 bits: 00 PC+1, 01 bus, 10 adder), ADDR2MUX (2 bits), ADDR1MUX, SR2MUX, DRMUX (1 bit each).
REQ-012 SHALL have output ALUK, 2 bits: 00 ADD, 01 AND, 10 NOT, 11 PASS.
REQ-013 SHALL have outputs Mem_OE and Mem_WE, 1 bit each, active-high; Halted, 1 bit, high in HALTED.

Function
REQ-014 SHALL implement states HALTED, FETCH1, FETCH2, FETCH3, DECODE, ADD, AND, NOT, BR, BR_TAKEN, JMP, JSR1, JSR2, LDR1, LDR2, LDR3, STR1, STR2, STR3, PAUSE1, PAUSE2.
REQ-015 HALTED SHALL go to FETCH1 on the first cycle Run=1; otherwise it SHALL stay in HALTED.
REQ-016 FETCH1 SHALL assert GatePC, LD_MAR and LD_PC with PCMUX=00, for exactly 1 cycle.
REQ-017 FETCH2 SHALL assert Mem_OE for MEM_WAIT cycles via an internal counter, and SHALL assert LD_MDR in the final cycle only.
REQ-018 FETCH3 SHALL assert GateMDR and LD_IR; DECODE SHALL assert LD_BEN and branch on Opcode.
REQ-019 DECODE SHALL map opcodes as follows: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR1, 0110 LDR1, 0111 STR1, 1101 PAUSE1; every other opcode SHALL go to FETCH1 as a NOP.
REQ-020 ADD, AND and NOT SHALL each assert GateALU, LD_REG and LD_CC for 1 cycle with the matching ALUK, SR2MUX=IR_5, and then go to FETCH1.
REQ-021 BR SHALL go to BR_TAKEN when BEN=1 (LD_PC, PCMUX=10, ADDR2MUX=PCoffset9, ADDR1MUX=PC); otherwise it SHALL go to FETCH1.
REQ-022 JSR1 SHALL load R7 from the PC (GatePC, DRMUX=1, LD_REG); JSR2 SHALL load PC from the adder; JMP SHALL load PC from the adder with ADDR1MUX=base register.
REQ-023 LDR1 SHALL load MAR from the adder; LDR2 SHALL perform a memory read as in FETCH2; LDR3 SHALL assert GateMDR, LD_REG and LD_CC.
REQ-024 STR1 SHALL load MAR; STR2 SHALL load MDR from the ALU in PASS mode; STR3 SHALL assert Mem_WE for MEM_WAIT cycles and then go to FETCH1.
REQ-025 Outputs SHALL be Moore (decoded from state only), and every strobe not listed for a state SHALL be 0.
REQ-026 The wait counter SHALL reload on entry to every memory state, and SHALL never wrap or carry between states.
REQ-027 Run asserted outside HALTED SHALL be ignored.

Reset
REQ-028 When Reset=1 at a clock edge, the FSM SHALL go to HALTED, clear the wait counter, and drive all outputs to 0 except Halted=1, including during a memory wait, which is aborted.
REQ-029 When Reset and Run are both high in the same cycle, Reset SHALL win.

Configuration
REQ-030 With macro LC3_PAUSE_INSTR_EN defined, opcode 1101 SHALL enter PAUSE1 (LD_LED=1), which holds until Continue=1, then PAUSE2, which holds until Continue=0, then FETCH1.
REQ-031 Without LC3_PAUSE_INSTR_EN, the PAUSE states SHALL not exist, opcode 1101 SHALL be a NOP to FETCH1, and LD_LED SHALL be tied to 0.

Verification
REQ-032 Reset then Run pulse -> Halted falls; FETCH1 strobes (GatePC, LD_MAR, LD_PC) high exactly 1 cycle later.
REQ-033 MEM_WAIT=3, Opcode=0001 -> Mem_OE high 3 cycles, LD_MDR only in the 3rd; ADD state asserts LD_REG and LD_CC with ALUK=00; total instruction is 7 cycles.
REQ-034 Opcode=0000 with BEN=1 -> BR_TAKEN asserts LD_PC with PCMUX=10; with BEN=0 -> FETCH1 directly, LD_PC never high in BR.
REQ-035 Opcode=0111, MEM_WAIT=2 -> Mem_WE high exactly 2 cycles in STR3 and LD_CC never high during the instruction.
REQ-036 Reset asserted during the 2nd cycle of the LDR2 wait -> next cycle shows Halted=1 and all strobes 0; a later Run restarts at FETCH1.
REQ-037 Opcode=1101 with LC3_PAUSE_INSTR_EN defined -> LD_LED held until Continue goes 1 then 0, then FETCH1; with the macro undefined -> FETCH1 immediately after DECODE.

Source files
------------

// File: rtl/lc3_control_fsm.sv
// LC-3 multicycle control unit: a Moore FSM that sequences fetch, decode and
// execute for ADD/AND/NOT/BR/JMP/JSR/LDR/STR, with a shared wait counter for
// memory accesses lasting MEM_WAIT cycles (legal 1..7).
// Optional feature macro: LC3_PAUSE_INSTR_EN enables the PAUSE instruction
// (opcode 1101) and the LD_LED strobe; without it 1101 is a NOP.
// Mux encodings: PCMUX 00 PC+1 / 01 bus / 10 adder; ADDR2MUX 00 zero /
// 01 offset6 / 10 PCoffset9 / 11 PCoffset11; ADDR1MUX 0 PC / 1 base register.
// Continue handshake: the PAUSE instruction waits for Continue to rise, then
// for Continue to fall, before fetching the next instruction, so one
// press/release of the operator switch releases exactly one PAUSE.
module lc3_control_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic       ADDR1MUX,
  output logic       SR2MUX,
  output logic       DRMUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Halted,
  output logic [4:0] dbg_state_o
);

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP, S_JSR1, S_JSR2,
    S_LDR1, S_LDR2, S_LDR3, S_STR1, S_STR2, S_STR3
`ifdef LC3_PAUSE_INSTR_EN
    , S_PAUSE1, S_PAUSE2
`endif
  } state_t;

  // Counter is loaded with MEM_WAIT-1 and the memory state ends when it hits 0.
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  function automatic logic is_mem(input state_t s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

  assign dbg_state_o = state_q;

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALTED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter reloads on entry to a memory state and
  // counts down only while staying in it, so it never wraps or carries over.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_HALTED:   if (Run) state_d = S_FETCH1;
      S_FETCH1:   state_d = S_FETCH2;
      S_FETCH2:   if (cnt_q == '0) state_d = S_FETCH3;
      S_FETCH3:   state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b0000: state_d = S_BR;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR1;
          4'b0110: state_d = S_LDR1;
          4'b0111: state_d = S_STR1;
`ifdef LC3_PAUSE_INSTR_EN
          4'b1101: state_d = S_PAUSE1;
`endif
          default: state_d = S_FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: state_d = S_FETCH1;
      S_BR:       state_d = BEN ? S_BR_TAKEN : S_FETCH1;
      S_BR_TAKEN: state_d = S_FETCH1;
      S_JMP:      state_d = S_FETCH1;
      S_JSR1:     state_d = S_JSR2;
      S_JSR2:     state_d = S_FETCH1;
      S_LDR1:     state_d = S_LDR2;
      S_LDR2:     if (cnt_q == '0) state_d = S_LDR3;
      S_LDR3:     state_d = S_FETCH1;
      S_STR1:     state_d = S_STR2;
      S_STR2:     state_d = S_STR3;
      S_STR3:     if (cnt_q == '0) state_d = S_FETCH1;
`ifdef LC3_PAUSE_INSTR_EN
      S_PAUSE1:   if (Continue) state_d = S_PAUSE2;
      S_PAUSE2:   if (!Continue) state_d = S_FETCH1;
`endif
      default:    state_d = S_HALTED;
    endcase
    if (is_mem(state_d) && (state_d != state_q)) begin
      cnt_d = WAIT_LOAD;
    end else if (is_mem(state_q) && (state_d == state_q)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Moore output decode: every strobe defaults low and only the listed
  // strobes rise in each state.
  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    ADDR2MUX   = 2'b00;
    ADDR1MUX   = 1'b0;
    SR2MUX     = 1'b0;
    DRMUX      = 1'b0;
    ALUK       = 2'b00;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    Halted     = 1'b0;
    case (state_q)
      S_HALTED: Halted = 1'b1;
      S_FETCH1: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b00; end
      S_FETCH2, S_LDR2: begin
        Mem_OE = 1'b1;
        LD_MDR = (cnt_q == '0);
      end
      S_FETCH3: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD: begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = 2'b00; SR2MUX = IR_5; end
      S_AND: begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = 2'b01; SR2MUX = IR_5; end
      S_NOT: begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = 2'b10; SR2MUX = IR_5; end
      S_BR_TAKEN: begin LD_PC = 1'b1; PCMUX = 2'b10; ADDR2MUX = 2'b10; ADDR1MUX = 1'b0; end
      S_JMP: begin LD_PC = 1'b1; PCMUX = 2'b10; ADDR2MUX = 2'b00; ADDR1MUX = 1'b1; end
      S_JSR1: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_JSR2: begin LD_PC = 1'b1; PCMUX = 2'b10; ADDR2MUX = 2'b11; ADDR1MUX = 1'b0; end
      S_LDR1, S_STR1: begin GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; end
      S_LDR3: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_STR2: begin GateALU = 1'b1; LD_MDR = 1'b1; ALUK = 2'b11; end
      S_STR3: Mem_WE = 1'b1;
      default: ;
    endcase
  end

`ifdef LC3_PAUSE_INSTR_EN
  // LED register loads for the whole PAUSE handshake.
  assign LD_LED = (state_q == S_PAUSE1) || (state_q == S_PAUSE2);
`else
  assign LD_LED = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: two instances (MEM_WAIT=3 and MEM_WAIT=2) share
// stimulus; per-cycle expected output vectors are queued per instance and
// compared at the falling edge.
module tb_lc3_control_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       ir5 = 1'b0;
  logic       ben = 1'b0;

  // Vector: {LD_MAR,LD_MDR,LD_IR,LD_BEN,LD_CC,LD_REG,LD_PC,LD_LED,GatePC,GateMDR,
  //          GateALU,GateMARMUX,PCMUX[1:0],ADDR2MUX[1:0],ADDR1MUX,SR2MUX,DRMUX,
  //          ALUK[1:0],Mem_OE,Mem_WE,Halted}
  wire [23:0] obs3, obs2;
  wire [4:0]  dbg3, dbg2;

  lc3_control_fsm #(.MEM_WAIT(3)) u_dut3 (
    .Clk(clk), .Reset(reset), .Run(run), .Continue(cont), .Opcode(opcode),
    .IR_5(ir5), .BEN(ben),
    .LD_MAR(obs3[23]), .LD_MDR(obs3[22]), .LD_IR(obs3[21]), .LD_BEN(obs3[20]),
    .LD_CC(obs3[19]), .LD_REG(obs3[18]), .LD_PC(obs3[17]), .LD_LED(obs3[16]),
    .GatePC(obs3[15]), .GateMDR(obs3[14]), .GateALU(obs3[13]), .GateMARMUX(obs3[12]),
    .PCMUX(obs3[11:10]), .ADDR2MUX(obs3[9:8]), .ADDR1MUX(obs3[7]), .SR2MUX(obs3[6]),
    .DRMUX(obs3[5]), .ALUK(obs3[4:3]), .Mem_OE(obs3[2]), .Mem_WE(obs3[1]),
    .Halted(obs3[0]), .dbg_state_o(dbg3)
  );

  lc3_control_fsm #(.MEM_WAIT(2)) u_dut2 (
    .Clk(clk), .Reset(reset), .Run(run), .Continue(cont), .Opcode(opcode),
    .IR_5(ir5), .BEN(ben),
    .LD_MAR(obs2[23]), .LD_MDR(obs2[22]), .LD_IR(obs2[21]), .LD_BEN(obs2[20]),
    .LD_CC(obs2[19]), .LD_REG(obs2[18]), .LD_PC(obs2[17]), .LD_LED(obs2[16]),
    .GatePC(obs2[15]), .GateMDR(obs2[14]), .GateALU(obs2[13]), .GateMARMUX(obs2[12]),
    .PCMUX(obs2[11:10]), .ADDR2MUX(obs2[9:8]), .ADDR1MUX(obs2[7]), .SR2MUX(obs2[6]),
    .DRMUX(obs2[5]), .ALUK(obs2[4:3]), .Mem_OE(obs2[2]), .Mem_WE(obs2[1]),
    .Halted(obs2[0]), .dbg_state_o(dbg2)
  );

  // ---------------- scoreboard ----------------
  logic [23:0] exp3_q[$];
  logic [23:0] exp2_q[$];
  logic [23:0] tr_q[$];
  logic        b_ir5;
  int checks = 0;
  int failures = 0;

  int sc_reset_cyc = -1;
  int sc_run2_cyc  = -1;
  int sc_run_extra = -1;
  int sc_cont_on   = 0;
  int sc_cont_off  = 0;

  typedef enum {P_HALT, P_F1, P_F2, P_F2L, P_F3, P_DEC, P_ADD, P_AND, P_NOT, P_BR,
                P_BRT, P_JMP, P_JSR1, P_JSR2, P_LDR1, P_LDR2, P_LDR2L, P_LDR3,
                P_STR1, P_STR2, P_STR3, P_P1, P_P2} ph_t;

  // Expected output vector for one cycle of a given phase.
  function automatic logic [23:0] ov(input ph_t p, input logic i5);
    logic [23:0] v;
    v = '0;
    case (p)
      P_HALT:  v[0] = 1'b1;
      P_F1:    begin v[23] = 1'b1; v[17] = 1'b1; v[15] = 1'b1; end
      P_F2:    v[2] = 1'b1;
      P_F2L:   begin v[2] = 1'b1; v[22] = 1'b1; end
      P_F3:    begin v[21] = 1'b1; v[14] = 1'b1; end
      P_DEC:   v[20] = 1'b1;
      P_ADD:   begin v[13] = 1'b1; v[18] = 1'b1; v[19] = 1'b1; v[6] = i5; v[4:3] = 2'b00; end
      P_AND:   begin v[13] = 1'b1; v[18] = 1'b1; v[19] = 1'b1; v[6] = i5; v[4:3] = 2'b01; end
      P_NOT:   begin v[13] = 1'b1; v[18] = 1'b1; v[19] = 1'b1; v[6] = i5; v[4:3] = 2'b10; end
      P_BR:    ;
      P_BRT:   begin v[17] = 1'b1; v[11:10] = 2'b10; v[9:8] = 2'b10; end
      P_JMP:   begin v[17] = 1'b1; v[11:10] = 2'b10; v[7] = 1'b1; end
      P_JSR1:  begin v[15] = 1'b1; v[5] = 1'b1; v[18] = 1'b1; end
      P_JSR2:  begin v[17] = 1'b1; v[11:10] = 2'b10; v[9:8] = 2'b11; end
      P_LDR1, P_STR1: begin v[12] = 1'b1; v[23] = 1'b1; v[7] = 1'b1; v[9:8] = 2'b01; end
      P_LDR2:  v[2] = 1'b1;
      P_LDR2L: begin v[2] = 1'b1; v[22] = 1'b1; end
      P_LDR3:  begin v[14] = 1'b1; v[18] = 1'b1; v[19] = 1'b1; end
      P_STR2:  begin v[13] = 1'b1; v[22] = 1'b1; v[4:3] = 2'b11; end
      P_STR3:  v[1] = 1'b1;
      P_P1, P_P2: v[16] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic add(input ph_t p, input int n);
    for (int i = 0; i < n; i++) tr_q.push_back(ov(p, b_ir5));
  endtask

  // Per-cycle expected trace of one instruction from HALTED through the next FETCH1.
  task automatic build_trace(input int mw, input logic [3:0] op, input logic b);
    tr_q.delete();
    add(P_HALT, 1); add(P_F1, 1); add(P_F2, mw - 1); add(P_F2L, 1);
    add(P_F3, 1); add(P_DEC, 1);
    case (op)
      4'b0001: add(P_ADD, 1);
      4'b0101: add(P_AND, 1);
      4'b1001: add(P_NOT, 1);
      4'b0000: begin add(P_BR, 1); if (b) add(P_BRT, 1); end
      4'b1100: add(P_JMP, 1);
      4'b0100: begin add(P_JSR1, 1); add(P_JSR2, 1); end
      4'b0110: begin add(P_LDR1, 1); add(P_LDR2, mw - 1); add(P_LDR2L, 1); add(P_LDR3, 1); end
      4'b0111: begin add(P_STR1, 1); add(P_STR2, 1); add(P_STR3, mw); end
`ifdef LC3_PAUSE_INSTR_EN
      // Continue is high in cycles 10..11: PAUSE1 until cycle 10, PAUSE2 in 11..12.
      4'b1101: begin add(P_P1, 7 - mw); add(P_P2, 2); end
`endif
      default: ;
    endcase
    add(P_F1, 1);
  endtask

  task automatic push_exp(input int which, input logic [23:0] v);
    if (which == 3) exp3_q.push_back(v);
    else exp2_q.push_back(v);
  endtask

  task automatic commit(input int which);
    foreach (tr_q[i]) push_exp(which, tr_q[i]);
  endtask

  task automatic check(input string tag, input string who, input int cyc,
                       input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s %s cyc=%0d observed=%h expected=%h", tag, who, cyc, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_scenario(input string tag);
    reset = 1'b1; run = 1'b0; cont = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int cyc = 0; cyc < 60 && (exp3_q.size() > 0 || exp2_q.size() > 0); cyc++) begin
      run   = (cyc == 0) || (cyc == sc_run2_cyc) || (cyc == sc_run_extra);
      reset = (cyc == sc_reset_cyc);
      cont  = (cyc >= sc_cont_on) && (cyc < sc_cont_off);
      @(negedge clk);
      if (exp3_q.size() > 0) check(tag, "mw3", cyc, obs3, exp3_q.pop_front());
      if (exp2_q.size() > 0) check(tag, "mw2", cyc, obs2, exp2_q.pop_front());
      @(posedge clk); #1;
    end
    run = 1'b0; reset = 1'b0; cont = 1'b0;
    if (exp3_q.size() > 0 || exp2_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout left_mw3=%0d left_mw2=%0d required=0", tag,
               exp3_q.size(), exp2_q.size());
      exp3_q.delete();
      exp2_q.delete();
    end
    sc_reset_cyc = -1; sc_run2_cyc = -1; sc_run_extra = -1;
    sc_cont_on = 0; sc_cont_off = 0;
  endtask

  task automatic do_instr(input string tag, input logic [3:0] op, input logic i5,
                          input logic b);
    opcode = op; ir5 = i5; ben = b; b_ir5 = i5;
    build_trace(3, op, b); commit(3);
    build_trace(2, op, b); commit(2);
    run_scenario(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Run pulse mid-fetch must be ignored.
    sc_run_extra = 4;
    do_instr("add_imm", 4'b0001, 1'b1, 1'b0);
    do_instr("add_reg", 4'b0001, 1'b0, 1'b0);
    do_instr("and", 4'b0101, 1'b0, 1'b0);
    do_instr("not", 4'b1001, 1'b1, 1'b0);
    do_instr("br_taken", 4'b0000, 1'b0, 1'b1);
    do_instr("br_not_taken", 4'b0000, 1'b0, 1'b0);
    do_instr("jmp", 4'b1100, 1'b0, 1'b0);
    do_instr("jsr", 4'b0100, 1'b0, 1'b0);
    do_instr("ldr", 4'b0110, 1'b0, 1'b0);
    do_instr("str", 4'b0111, 1'b0, 1'b1);
    do_instr("nop_0010", 4'b0010, 1'b0, 1'b0);
    do_instr("nop_1111", 4'b1111, 1'b1, 1'b1);
    sc_cont_on = 10; sc_cont_off = 12;
    do_instr("pause_1101", 4'b1101, 1'b0, 1'b0);

    // Reset (together with Run) during the LDR2 wait, then restart with Run.
    opcode = 4'b0110; ir5 = 1'b0; ben = 1'b0; b_ir5 = 1'b0;
    for (int w = 2; w <= 3; w++) begin
      build_trace(w, 4'b0110, 1'b0);
      for (int i = 0; i < 9; i++) push_exp(w, tr_q[i]);
      push_exp(w, ov(P_HALT, 1'b0));
      push_exp(w, ov(P_HALT, 1'b0));
      for (int i = 1; i < tr_q.size(); i++) push_exp(w, tr_q[i]);
    end
    sc_reset_cyc = 8; sc_run_extra = 8; sc_run2_cyc = 10;
    run_scenario("ldr_reset_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
